// File: rtl/rr_pkg.sv
// Shared types and helpers for the round-robin handshake arbiter.
package rr_pkg;

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        GRANT = 1'b1
    } rr_state_e;

    // (idx + 1) mod cnt, written as a compare so non-power-of-2 counts stay cheap
    function automatic int unsigned rr_next_idx(input int unsigned idx, input int unsigned cnt);
        return (idx + 32'd1 >= cnt) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
    import rr_pkg::*;
#(
    parameter int unsigned REQCNT   = 8,
    parameter int unsigned REQWIDTH = $clog2(REQCNT)
) (
    input  logic [REQCNT-1:0]   req,
    input  logic [REQWIDTH-1:0] ptr,
    output logic                found,
    output logic [REQWIDTH-1:0] idx
);

    int unsigned cand;

    // Scan from the farthest offset down so the nearest hit overwrites the rest
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 32'd0;
        for (int i = REQCNT - 1; i >= 0; i--) begin
            cand = 32'(ptr) + 32'(i);
            if (cand >= REQCNT) begin
                cand = cand - REQCNT;
            end
            if (req[REQWIDTH'(cand)]) begin
                found = 1'b1;
                idx   = REQWIDTH'(cand);
            end
        end
    end

endmodule

// File: rtl/rr_arb_hs.sv
// Round-robin arbiter with per-packet grant locking and a hold-length limit.
module rr_arb_hs
    import rr_pkg::*;
#(
    parameter int unsigned REQCNT   = 8,
    parameter int unsigned REQWIDTH = $clog2(REQCNT),
    parameter bit          LOCK_EN  = 1'b1,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [REQCNT-1:0]   req_i,
    input  logic [REQCNT-1:0]   last_i,
    input  logic                ack_i,
    output logic [REQCNT-1:0]   gnt_o,
    output logic [REQWIDTH-1:0] gnt_num_o,
    output logic                gnt_val_o,
    output logic                ovf_o
);

    localparam int unsigned HOLDW = $clog2(MAX_HOLD + 1);

    rr_state_e            state_q, state_d;
    logic [REQWIDTH-1:0]  ptr_q, ptr_d;
    logic [HOLDW-1:0]     hold_q, hold_d, hold_inc;
    logic [REQCNT-1:0]    gnt_d;
    logic [REQWIDTH-1:0]  num_d;
    logic                 val_d;
    logic                 ovf_d;
    logic                 rel_c;
    logic                 pick_found;
    logic [REQWIDTH-1:0]  pick_idx;

    rr_pick #(
        .REQCNT   (REQCNT),
        .REQWIDTH (REQWIDTH)
    ) u_pick (
        .req   (req_i),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign hold_inc = hold_q + HOLDW'(1);

    // Next state and next registered outputs
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gnt_d   = gnt_o;
        num_d   = gnt_num_o;
        val_d   = gnt_val_o;
        ovf_d   = 1'b0;
        rel_c   = 1'b0;
        case (state_q)
            ARB: begin
                gnt_d  = '0;
                num_d  = '0;
                val_d  = 1'b0;
                hold_d = '0;
                if (pick_found) begin
                    state_d = GRANT;
                    gnt_d   = REQCNT'(1) << pick_idx;
                    num_d   = pick_idx;
                    val_d   = 1'b1;
                end
            end
            default: begin
                // A dropped request is an abort even if ack_i is high
                if (!req_i[gnt_num_o]) begin
                    rel_c = 1'b1;
                end else if (ack_i) begin
                    if (!LOCK_EN || last_i[gnt_num_o]) begin
                        rel_c = 1'b1;
                    end else if (hold_inc == HOLDW'(MAX_HOLD)) begin
                        rel_c = 1'b1;
                        ovf_d = 1'b1;
                    end else begin
                        hold_d = hold_inc;
                    end
                end
                if (rel_c) begin
                    state_d = ARB;
                    ptr_d   = REQWIDTH'(rr_next_idx(32'(gnt_num_o), REQCNT));
                    hold_d  = '0;
                    gnt_d   = '0;
                    num_d   = '0;
                    val_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ARB;
            ptr_q     <= '0;
            hold_q    <= '0;
            gnt_o     <= '0;
            gnt_num_o <= '0;
            gnt_val_o <= 1'b0;
            ovf_o     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gnt_o     <= gnt_d;
            gnt_num_o <= num_d;
            gnt_val_o <= val_d;
            ovf_o     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_rr_arb_hs.sv
// Directed bench for rr_arb_hs: locked 4-way, unlocked 4-way and 5-way instances.
module tb_rr_arb_hs;

    logic clk = 1'b0;
    logic rst_n;

    logic [3:0] a_req, a_last, a_gnt;
    logic [1:0] a_num;
    logic       a_ack, a_val, a_ovf;

    logic [3:0] b_req, b_last, b_gnt;
    logic [1:0] b_num;
    logic       b_ack, b_val, b_ovf;

    logic [4:0] c_req, c_last, c_gnt;
    logic [2:0] c_num;
    logic       c_ack, c_val, c_ovf;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rr_arb_hs #(.REQCNT(4), .LOCK_EN(1'b1), .MAX_HOLD(3)) u_a (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(a_req), .last_i(a_last), .ack_i(a_ack),
        .gnt_o(a_gnt), .gnt_num_o(a_num), .gnt_val_o(a_val), .ovf_o(a_ovf)
    );

    rr_arb_hs #(.REQCNT(4), .LOCK_EN(1'b0), .MAX_HOLD(3)) u_b (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(b_req), .last_i(b_last), .ack_i(b_ack),
        .gnt_o(b_gnt), .gnt_num_o(b_num), .gnt_val_o(b_val), .ovf_o(b_ovf)
    );

    rr_arb_hs #(.REQCNT(5), .LOCK_EN(1'b1), .MAX_HOLD(3)) u_c (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(c_req), .last_i(c_last), .ack_i(c_ack),
        .gnt_o(c_gnt), .gnt_num_o(c_num), .gnt_val_o(c_val), .ovf_o(c_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic exp_out(input string tag, input logic [63:0] gnt, input logic [7:0] num,
                           input logic val, input logic ovf, input bit ev, input int en, input bit eo);
        logic [63:0] eg;
        eg = ev ? (64'd1 << en) : 64'd0;
        chk({tag, ".val"}, 64'(val), 64'(ev));
        chk({tag, ".gnt"}, gnt, eg);
        chk({tag, ".num"}, 64'(num), ev ? 64'(en) : 64'd0);
        chk({tag, ".ovf"}, 64'(ovf), 64'(eo));
    endtask

    task automatic ea(input string tag, input bit ev, input int en, input bit eo);
        exp_out({"a.", tag}, 64'(a_gnt), 8'(a_num), a_val, a_ovf, ev, en, eo);
    endtask

    task automatic eb(input string tag, input bit ev, input int en, input bit eo);
        exp_out({"b.", tag}, 64'(b_gnt), 8'(b_num), b_val, b_ovf, ev, en, eo);
    endtask

    task automatic ec(input string tag, input bit ev, input int en, input bit eo);
        exp_out({"c.", tag}, 64'(c_gnt), 8'(c_num), c_val, c_ovf, ev, en, eo);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_req = '0; a_last = '0; a_ack = 1'b0;
        b_req = '0; b_last = '0; b_ack = 1'b0;
        c_req = '0; c_last = '0; c_ack = 1'b0;
        #2;
        ea("rst", 0, 0, 0);
        eb("rst", 0, 0, 0);
        ec("rst", 0, 0, 0);
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;

        // Two requesters, single-beat packets: 1, bubble, 3, bubble, 1
        a_req = 4'b1010; a_last = 4'b1111; a_ack = 1'b1;
        step(); ea("p1_g1", 1, 1, 0);
        step(); ea("p1_b1", 0, 0, 0);
        step(); ea("p1_g3", 1, 3, 0);
        step(); ea("p1_b2", 0, 0, 0);
        step(); ea("p1_g1b", 1, 1, 0);
        step(); ea("p1_b3", 0, 0, 0);
        a_req = '0;
        step(); ea("idle", 0, 0, 0);

        // Hold limit: ptr=2, only requester 0, no last -> 3 beats then ovf
        a_req = 4'b0001; a_last = 4'b0000;
        step(); ea("ovf_g0", 1, 0, 0);
        step(); ea("ovf_beat1", 1, 0, 0);
        step(); ea("ovf_beat2", 1, 0, 0);
        a_req = 4'b0011;
        step(); ea("ovf_rel", 0, 0, 1);
        step(); ea("ovf_ptr1", 1, 1, 0);
        a_last = 4'b1111;
        step(); ea("ovf_rel2", 0, 0, 0);

        // Last beat coincides with hold limit: no ovf
        a_req = 4'b1000; a_last = 4'b0000;
        step(); ea("lm_g3", 1, 3, 0);
        step(); ea("lm_beat1", 1, 3, 0);
        step(); ea("lm_beat2", 1, 3, 0);
        a_last = 4'b1000;
        step(); ea("lm_rel", 0, 0, 0);

        // Abort of index 2 with ack high, next grant to 3
        a_req = 4'b1100; a_ack = 1'b0; a_last = 4'b1111;
        step(); ea("ab_g2", 1, 2, 0);
        step(); ea("ab_noack", 1, 2, 0);
        a_req = 4'b1000; a_ack = 1'b1;
        step(); ea("ab_rel", 0, 0, 0);
        step(); ea("ab_g3", 1, 3, 0);
        a_ack = 1'b0;
        step(); ea("ab_hold3", 1, 3, 0);

        // Asynchronous reset mid-grant, then arbitration restarts from ptr=0
        #2 rst_n = 1'b0;
        #1;
        ea("arst", 0, 0, 0);
        #1 rst_n = 1'b1;
        a_req = 4'b1001; a_ack = 1'b1; a_last = 4'b1111;
        step(); ea("post_g0", 1, 0, 0);
        step(); ea("post_b0", 0, 0, 0);
        step(); ea("post_g3", 1, 3, 0);
        step(); ea("post_b1", 0, 0, 0);
        a_req = '0;

        // Unlocked: one beat per grant, rotation 0,1,2,3,0
        b_req = 4'b1111; b_ack = 1'b1; b_last = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            step(); eb($sformatf("rot_g%0d", k), 1, k % 4, 0);
            step(); eb($sformatf("rot_b%0d", k), 0, 0, 0);
        end
        b_req = '0;

        // Five requesters: wrap from ptr=4 back to 0
        c_req = 5'b10001; c_ack = 1'b1; c_last = 5'b11111;
        for (int k = 0; k < 4; k++) begin
            step(); ec($sformatf("wrap_g%0d", k), 1, (k % 2 == 0) ? 0 : 4, 0);
            step(); ec($sformatf("wrap_b%0d", k), 0, 0, 0);
        end
        c_req = '0;
        step(); ec("idle", 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rr_arb_hs.md
RR_ARB_HS -- requirements
Module: rr_arb_hs

Interface
REQ-001 Parameter REQCNT, default 8; number of requesters; legal range 2..64.
REQ-002 Parameter REQWIDTH, default $clog2(REQCNT); width of grant index.
REQ-003 Parameter LOCK_EN, default 1; 1 holds the grant until the packet's last beat, 0 re-arbitrates after every beat.
REQ-004 Parameter MAX_HOLD, default 16; maximum beats per grant when LOCK_EN=1; legal range 1..255.
REQ-005 clk_i  input  1  sole clock, rising edge.
REQ-006 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-007 req_i  input  REQCNT  per-requester request, level, held until granted beat transfers.
REQ-008 last_i  input  REQCNT  per-requester last-beat marker, sampled only for the granted requester.
REQ-009 ack_i  input  1  downstream accepts the current beat.
REQ-010 gnt_o  output  REQCNT  one-hot grant, registered.
REQ-011 gnt_num_o  output  REQWIDTH  binary index of granted requester, registered.
REQ-012 gnt_val_o  output  1  gnt_o/gnt_num_o valid, registered.
REQ-013 ovf_o  output  1  one-cycle pulse: grant force-released at MAX_HOLD.

Function
REQ-014 Beat transfer: the cycle in which gnt_val_o=1, req_i[gnt_num_o]=1 and ack_i=1.
REQ-015 State machine: two states, ARB and GRANT.
REQ-016 ARB, no req_i bit set: the block stays in ARB with all outputs 0.
REQ-017 ARB, any req_i bit set: the block selects the first set bit at or above ptr, wrapping from REQCNT-1 to 0, and moves to GRANT.
REQ-018 On the ARB-to-GRANT transition, gnt_o, gnt_num_o and gnt_val_o are valid the cycle after req_i is sampled (latency 1).
REQ-019 GRANT: gnt_o and gnt_num_o are stable; gnt_o equals 1<<gnt_num_o.
REQ-020 GRANT, beat transfer with last_i[g]=1, or with LOCK_EN=0: release the grant.
REQ-021 Release: gnt_val_o=0 and gnt_o=0 next cycle, ptr=(g+1) mod REQCNT, state ARB, which gives one bubble cycle between grants.
REQ-022 GRANT, req_i[g]=0 without a transfer (abort): release as in REQ-021 and do not pulse ovf_o.
REQ-023 GRANT, LOCK_EN=1: hold_cnt increments per beat transfer.
REQ-024 A transfer that brings hold_cnt to MAX_HOLD with last_i[g]=0 causes a release and pulses ovf_o for one cycle concurrent with the release.
REQ-025 hold_cnt clears on every release; its width is $clog2(MAX_HOLD+1).
REQ-026 Last beat and MAX_HOLD reached in the same cycle: normal release, ovf_o=0.
REQ-027 ack_i while gnt_val_o=0 is ignored.
REQ-028 ack_i with req_i[g]=0 counts as an abort, not a transfer.
REQ-029 ptr updates only on release and always wraps modulo REQCNT, including for non-power-of-2 REQCNT.
REQ-030 A requester that releases becomes lowest priority; no requester waits more than REQCNT-1 grants.

Reset
REQ-031 While rst_n_i=0: state=ARB, ptr=0, hold_cnt=0, gnt_o=0, gnt_num_o=0, gnt_val_o=0, ovf_o=0.
REQ-032 Reset asserted mid-grant: the grant drops asynchronously with no ovf_o pulse.
REQ-033 First arbitration after reset deassertion starts from ptr=0.

Structure
REQ-034 Package rr_pkg holds the state enum typedef (ARB, GRANT) and a function computing (idx+1) mod REQCNT.
REQ-035 Sub-module rr_pick is purely combinational: inputs req vector and ptr; outputs found flag and index.
REQ-036 rr_arb_hs contains only the FSM, ptr, hold_cnt and output registers.

Verification (REQCNT=4, MAX_HOLD=3 unless stated)
REQ-037 req_i=4'b1010 from reset, ack_i=1, last_i=4'b1111 -> grants index 1, then 3, then 1, each gnt_val_o high 1 cycle followed by a 1-cycle bubble.
REQ-038 req_i=4'b0001, last_i=0, ack_i=1, LOCK_EN=1 -> index 0 granted 3 beats, ovf_o pulses on the 3rd beat, ptr=1 next.
REQ-039 Index 2 granted, req_i[2] drops before ack_i -> gnt_val_o=0 next cycle, ovf_o=0, next grant goes to index 3 if requesting.
REQ-040 LOCK_EN=0, req_i=4'b1111, ack_i=1 -> grant rotates 0,1,2,3,0, with one beat per grant.
REQ-041 rst_n_i pulled low while index 3 is granted -> all outputs 0 immediately; after release, req_i=4'b1000 -> grant index 3 from ptr=0.
REQ-042 REQCNT=5, req_i=5'b10001, last_i all 1 -> grants alternate 4 and 0, showing the wrap from ptr=4 to ptr=0.
